fluid_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one fluid (Valid/Retry) pipeline stage between NumInp requesters.
- Each requester presents data with a Valid/Retry handshake. The winner's data is captured into an internal 2-entry output buffer, which drives a single fluid output.
- Sits in front of a chain of fflop stages so that several producers can feed one shared datapath without losing or duplicating beats.

---
 rtl/fluid_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_fluid_rr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fluid_rr_arbiter.sv
// Round-robin arbiter sharing one fluid (Valid/Retry) stage between NumInp requesters,
// with a 2-entry FIFO output buffer. Optional packet locking via `FLUID_ARB_LOCK_EN.
module fluid_rr_arbiter #(
    parameter  int Size   = 8,
    parameter  int NumInp = 4,
    localparam int IdxW   = $clog2(NumInp)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [NumInp*Size-1:0] inp_data,
    input  logic [NumInp-1:0]      inpValid,
`ifdef FLUID_ARB_LOCK_EN
    input  logic [NumInp-1:0]      inpLast,
`endif
    output logic [NumInp-1:0]      inpRetry,
    output logic [Size-1:0]        q,
    output logic [IdxW-1:0]        qSrc,
    output logic                   qValid,
    input  logic                   qRetry
);

    logic [Size-1:0] buf_data [2];
    logic [IdxW-1:0] buf_src  [2];
    logic            head;
    logic [1:0]      count;
    logic [IdxW-1:0] ptr;

    logic            flush;
    logic            full;
    logic            grant;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] ptr_next;
    logic            push;
    logic            pop;
    logic            wr_idx;

`ifdef FLUID_ARB_LOCK_EN
    logic            locked;
    logic [IdxW-1:0] lock_src;
`endif

    assign flush  = reset | clear;
    assign full   = (count == 2'd2);
    assign qValid = (count != 2'd0);
    assign q      = buf_data[head];
    assign qSrc   = buf_src[head];
    assign push   = grant & ~full & ~flush;
    assign pop    = qValid & ~qRetry;
    // The tail slot sits one past the head when a single entry is held.
    assign wr_idx = head ^ count[0];
    assign ptr_next = (win == IdxW'(NumInp - 1)) ? '0 : win + 1'b1;

    // First valid requester at or after ptr, wrapping modulo NumInp.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        for (int k = 0; k < NumInp; k++) begin
            if (!grant && inpValid[(int'(ptr) + k) % NumInp]) begin
                grant = 1'b1;
                win   = IdxW'((int'(ptr) + k) % NumInp);
            end
        end
`ifdef FLUID_ARB_LOCK_EN
        if (locked) begin
            grant = inpValid[lock_src];
            win   = lock_src;
        end
`endif
    end

    always_comb begin
        inpRetry = '1;
        if (push) inpRetry[win] = 1'b0;
    end

    // NOTE: state uses non-blocking assignments; the buffer storage is reset too
    // because q/qSrc read it directly and must show 0 after reset or clear.
    always_ff @(posedge clk) begin
        if (flush) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_src[0]  <= '0;
            buf_src[1]  <= '0;
            head        <= 1'b0;
            count       <= 2'd0;
            ptr         <= '0;
`ifdef FLUID_ARB_LOCK_EN
            locked      <= 1'b0;
            lock_src    <= '0;
`endif
        end else begin
            if (push) begin
                buf_data[wr_idx] <= inp_data[win*Size +: Size];
                buf_src[wr_idx]  <= win;
            end
            if (pop) head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push) begin
`ifdef FLUID_ARB_LOCK_EN
                if (inpLast[win]) begin
                    locked <= 1'b0;
                    ptr    <= ptr_next;
                end else begin
                    locked   <= 1'b1;
                    lock_src <= win;
                end
`else
                ptr <= ptr_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fluid_rr_arbiter.sv
// Self-checking bench for fluid_rr_arbiter: table-driven grant vectors plus a
// scoreboard of expected output beats; lock sequence under `FLUID_ARB_LOCK_EN.
module tb_fluid_rr_arbiter;

    localparam int Size   = 8;
    localparam int NumInp = 4;
    localparam int IdxW   = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clear;
    logic [NumInp*Size-1:0] inp_data;
    logic [NumInp-1:0]      inpValid;
    logic [NumInp-1:0]      inpRetry;
`ifdef FLUID_ARB_LOCK_EN
    logic [NumInp-1:0]      inpLast;
`endif
    logic [Size-1:0]        q;
    logic [IdxW-1:0]        qSrc;
    logic                   qValid;
    logic                   qRetry;

    fluid_rr_arbiter #(.Size(Size), .NumInp(NumInp)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .inp_data (inp_data),
        .inpValid (inpValid),
`ifdef FLUID_ARB_LOCK_EN
        .inpLast  (inpLast),
`endif
        .inpRetry (inpRetry),
        .q        (q),
        .qSrc     (qSrc),
        .qValid   (qValid),
        .qRetry   (qRetry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        q_retry;
        logic        clr;
        logic [3:0]  exp_retry;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
    } beat_t;

    localparam logic [31:0] D0  = 32'h33221100;
    localparam logic [31:0] DBP = 32'h33A51100;
    localparam logic [31:0] DCL = 32'h3322115A;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check before the edge, then advance the model.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic qr,
                        input logic clr, input logic [3:0] exp_r, input string tag);
        beat_t exp_b;
        beat_t nb;
        inpValid = v;
        inp_data = d;
        qRetry   = qr;
        clear    = clr;
        @(negedge clk);
        check({tag, " inpRetry"}, 32'(inpRetry), 32'(exp_r));
        check({tag, " qValid"}, 32'(qValid), 32'(sb.size() != 0));
        if (sb.size() != 0 && !qr) begin
            exp_b = sb.pop_front();
            check({tag, " q"}, 32'(q), 32'(exp_b.data));
            check({tag, " qSrc"}, 32'(qSrc), 32'(exp_b.src));
        end
        if (!clr) begin
            for (int i = 0; i < NumInp; i++) begin
                if (!exp_r[i]) begin
                    nb.data = d[i*8 +: 8];
                    nb.src  = 2'(i);
                    sb.push_back(nb);
                end
            end
        end else begin
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rotation from reset: ptr 0
        vecs.push_back('{4'b1111, D0,  1'b0, 1'b0, 4'b1110});
        vecs.push_back('{4'b1111, D0,  1'b0, 1'b0, 4'b1101});
        vecs.push_back('{4'b1111, D0,  1'b0, 1'b0, 4'b1011});
        vecs.push_back('{4'b1111, D0,  1'b0, 1'b0, 4'b0111});
        vecs.push_back('{4'b1111, D0,  1'b0, 1'b0, 4'b1110});
        // sparse and wrap: ptr 1 -> ch2 (ptr 3) -> ch1 (ptr 2) -> ch3 (ptr 0)
        vecs.push_back('{4'b0100, D0,  1'b0, 1'b0, 4'b1011});
        vecs.push_back('{4'b0010, D0,  1'b0, 1'b0, 4'b1101});
        vecs.push_back('{4'b1001, D0,  1'b0, 1'b0, 4'b0111});
        vecs.push_back('{4'b0000, D0,  1'b0, 1'b0, 4'b1111});
        // backpressure on ch2: two beats fill the buffer, then release
        vecs.push_back('{4'b0100, DBP, 1'b1, 1'b0, 4'b1011});
        vecs.push_back('{4'b0100, DBP, 1'b1, 1'b0, 4'b1011});
        vecs.push_back('{4'b0100, DBP, 1'b1, 1'b0, 4'b1111});
        vecs.push_back('{4'b0100, DBP, 1'b1, 1'b0, 4'b1111});
        vecs.push_back('{4'b0000, DBP, 1'b0, 1'b0, 4'b1111});
        vecs.push_back('{4'b0000, DBP, 1'b0, 1'b0, 4'b1111});
        vecs.push_back('{4'b0000, DBP, 1'b0, 1'b0, 4'b1111});
        // clear mid-stream: ptr 3, fill with ch0, clear, ptr back to 0 picks ch0 over ch1
        vecs.push_back('{4'b0001, DCL, 1'b1, 1'b0, 4'b1110});
        vecs.push_back('{4'b0001, DCL, 1'b1, 1'b0, 4'b1110});
        vecs.push_back('{4'b0001, DCL, 1'b1, 1'b0, 4'b1111});
        vecs.push_back('{4'b0001, DCL, 1'b1, 1'b1, 4'b1111});
        vecs.push_back('{4'b0011, DCL, 1'b0, 1'b0, 4'b1110});
        vecs.push_back('{4'b0000, DCL, 1'b0, 1'b0, 4'b1111});
        vecs.push_back('{4'b0000, DCL, 1'b0, 1'b0, 4'b1111});

        reset    = 1'b1;
        clear    = 1'b0;
        inpValid = 4'b1111;
        inp_data = D0;
        qRetry   = 1'b0;
`ifdef FLUID_ARB_LOCK_EN
        inpLast  = 4'b1111;
`endif
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset qValid", 32'(qValid), 32'd0);
            check("reset inpRetry", 32'(inpRetry), 32'hF);
            check("reset q", 32'(q), 32'd0);
            check("reset qSrc", 32'(qSrc), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].q_retry, vecs[i].clr,
                 vecs[i].exp_retry, $sformatf("vec%0d", i));
        end

`ifdef FLUID_ARB_LOCK_EN
        // ptr is 1: ch1 sends a 3-beat packet while ch0/ch2 stay valid
        inpLast = 4'b1101;
        step(4'b0111, D0, 1'b0, 1'b0, 4'b1101, "lock beat1");
        step(4'b0111, D0, 1'b0, 1'b0, 4'b1101, "lock beat2");
        inpLast = 4'b1111;
        step(4'b0111, D0, 1'b0, 1'b0, 4'b1101, "lock beat3");
        step(4'b0111, D0, 1'b0, 1'b0, 4'b1011, "lock after");
        step(4'b0000, D0, 1'b0, 1'b0, 4'b1111, "lock drain1");
        step(4'b0000, D0, 1'b0, 1'b0, 4'b1111, "lock drain2");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
